reservation_station: RTL and testbench
======================================

Name: reservation_station

Overview:
- Tomasulo reservation station between decode/dispatch and one functional unit.
- Holds dispatched instructions tagged with their ROB entry number (ROBEN) and captures missing operands from the CDB.
- Issues ready instructions to the FU, whose result returns on the CDB to the ROB.
- Operand values or tags come from the ROB read ports (RP1_*) and the register status table at dispatch.

Parameters:
- ENTRIES, 4: number of RS slots (2..8).
- ROBEN_W, 5: ROB tag width; tag 0 means "no producer / value valid".
- DATA_W, 32: operand and result width.
- OPC_W, 12: opcode width, matching the decoded opcode encoding.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- Alloc_Valid  in  1  dispatch request this cycle.
- Alloc_opcode  in  OPC_W  decoded opcode.
- Alloc_ROBEN  in  ROBEN_W  destination ROB entry (nonzero).
- Alloc_Q1, Alloc_Q2  in  ROBEN_W  producer tags of the operands; 0 means the matching V is valid.
- Alloc_V1, Alloc_V2  in  DATA_W  operand values, meaningful when the matching Q is 0.
- Alloc_Imm  in  DATA_W  immediate, passed through unchanged.
- CDB_ROBEN  in  ROBEN_W  broadcast tag; 0 means no broadcast.
- CDB_Write_Data  in  DATA_W  broadcast value.
- FLUSH_Flag  in  1  misprediction flush from the ROB.
- FULL_FLAG  out  1  all slots busy.
- Issue_Valid  out  1  a ready slot is presented.
- FU_Ready  in  1  FU accepts the presented slot this cycle.
- Issue_opcode  out  OPC_W  opcode of the presented slot.
- Issue_ROBEN  out  ROBEN_W  ROBEN of the presented slot.
- Issue_V1, Issue_V2, Issue_Imm  out  DATA_W  operands and immediate of the presented slot.

Behaviour:
- Per-slot state: Busy, opcode, ROBEN, Q1, Q2, V1, V2, Imm.
- A slot is ready when Busy=1, Q1=0 and Q2=0.
- Reset (rst=0, asynchronous): all Busy=0, all Q=0, all V/Imm=0. Outputs: FULL_FLAG=0, Issue_Valid=0, Issue_* fields 0.
- Reset asserted mid-operation discards all slots immediately; no issue occurs on the following edge.
- Allocation:
  - On a rising edge with Alloc_Valid=1, FULL_FLAG=0 and FLUSH_Flag=0, the lowest-index free slot is written and Busy is set.
  - Alloc_Valid while FULL_FLAG=1 is dropped silently. FULL_FLAG is computed from registered Busy only, so a slot being freed by issue in the same cycle does not enable allocation.
- CDB capture:
  - On each edge with CDB_ROBEN≠0, every busy slot with Qk==CDB_ROBEN takes Vk←CDB_Write_Data and Qk←0 (both operands may match).
  - Dispatch bypass: if Alloc_Qk==CDB_ROBEN≠0 in the allocation cycle, the new slot stores the CDB value with Qk=0.
- Issue (combinational select):
  - Issue_Valid=1 when any slot is ready; the lowest-index ready slot drives Issue_*.
  - When Issue_Valid=0, Issue_* fields are 0.
  - On an edge with Issue_Valid & FU_Ready, that slot's Busy clears.
  - Presented fields stay stable while FU_Ready=0, unless a lower-index slot becomes ready, which then takes priority.
- Latency:
  - A slot allocated with both Q=0 at edge N is presented in the cycle after edge N.
  - An operand captured at edge N makes its slot presentable in the cycle after edge N.
  - A value on the CDB never issues in the same cycle it is broadcast.
- Flush: an edge with FLUSH_Flag=1 clears all Busy. Allocation, capture and issue-free in that cycle are ignored. Issue_Valid may still be 1 during the flush cycle; the FU must also honour FLUSH_Flag.
- Tags are compared at full ROBEN_W width; there is no arithmetic on tags and no wrap-around handling.

Decomposition:
- Shared package holds:
  - the opcode constants (same encoding as the decoder and ROB);
  - ROBEN_W and DATA_W defaults;
  - the constant NO_TAG=0.
- One sub-module, rs_priority_select: a parameterised lowest-index-set encoder producing a one-hot grant and a valid bit. It is instantiated twice, once for the free-slot search and once for the ready-slot search.

Test Plan:
- Reset then allocate add, ROBEN=3, Q1=0 V1=5, Q2=0 V2=7 -> next cycle Issue_Valid=1, Issue_ROBEN=3, V1=5, V2=7. With FU_Ready=1 the following cycle shows Issue_Valid=0.
- Allocate ROBEN=4 with Q1=1, Q2=2 -> Issue_Valid=0. CDB 1/123 then CDB 2/456 -> Issue_V1=123, Issue_V2=456 one cycle after the second broadcast.
- Allocate ROBEN=5 with Q1=6 while CDB_ROBEN=6 / 999 in the same cycle -> slot stores V1=999, Q1=0, and issues next cycle.
- Allocate 4 slots with unresolved tags -> FULL_FLAG=1. A 5th Alloc_Valid is dropped. Resolve slot 2 and accept it -> FULL_FLAG=0 one edge after acceptance.
- Slots 0 and 2 both ready with FU_Ready=0 for 3 cycles -> slot 0 held on Issue_* throughout. FU_Ready=1 -> slot 2 presented next cycle.
- 3 busy slots plus Alloc_Valid with FLUSH_Flag=1 -> all Busy=0 and FULL_FLAG=0 after the edge, no new slot. Drop rst mid-run -> Issue_Valid=0 immediately.

Source files
------------

// File: rtl/reservation_station_pkg.sv
// -----------------------------------------------------------------------------
// reservation_station_pkg
// Shared definitions for the reservation station slice: opcode encoding (the
// same values the decoder and ROB use), default widths and the "no producer"
// tag value.
// -----------------------------------------------------------------------------
package reservation_station_pkg;

    localparam int RS_ROBEN_W = 5;
    localparam int RS_DATA_W  = 32;
    localparam int RS_OPC_W   = 12;

    // Tag value meaning "operand already valid" / "no broadcast this cycle".
    localparam logic [RS_ROBEN_W-1:0] NO_TAG = '0;

    // Decoded opcode encoding shared with decode and ROB.
    typedef enum logic [RS_OPC_W-1:0] {
        OPC_NOP = 12'h000,
        OPC_ADD = 12'h001,
        OPC_SUB = 12'h002,
        OPC_AND = 12'h004,
        OPC_OR  = 12'h008,
        OPC_XOR = 12'h010,
        OPC_SLL = 12'h020,
        OPC_SRL = 12'h040,
        OPC_SLT = 12'h080
    } rs_opcode_e;

endpackage

// File: rtl/reservation_station_if.sv
// -----------------------------------------------------------------------------
// reservation_station_if
// Bundles the dispatch, CDB, flush and FU-issue signals of the reservation
// station.
//   master : dispatch/ROB/FU side (drives Alloc_*, CDB_*, FLUSH_Flag, FU_Ready)
//   slave  : the reservation station (drives FULL_FLAG and Issue_*)
// -----------------------------------------------------------------------------
interface reservation_station_if
    import reservation_station_pkg::*;
#(
    parameter int ROBEN_W = RS_ROBEN_W,
    parameter int DATA_W  = RS_DATA_W,
    parameter int OPC_W   = RS_OPC_W
) ();

    logic               Alloc_Valid;
    logic [OPC_W-1:0]   Alloc_opcode;
    logic [ROBEN_W-1:0] Alloc_ROBEN;
    logic [ROBEN_W-1:0] Alloc_Q1;
    logic [ROBEN_W-1:0] Alloc_Q2;
    logic [DATA_W-1:0]  Alloc_V1;
    logic [DATA_W-1:0]  Alloc_V2;
    logic [DATA_W-1:0]  Alloc_Imm;
    logic [ROBEN_W-1:0] CDB_ROBEN;
    logic [DATA_W-1:0]  CDB_Write_Data;
    logic               FLUSH_Flag;
    logic               FULL_FLAG;
    logic               Issue_Valid;
    logic               FU_Ready;
    logic [OPC_W-1:0]   Issue_opcode;
    logic [ROBEN_W-1:0] Issue_ROBEN;
    logic [DATA_W-1:0]  Issue_V1;
    logic [DATA_W-1:0]  Issue_V2;
    logic [DATA_W-1:0]  Issue_Imm;

    modport master (
        output Alloc_Valid, Alloc_opcode, Alloc_ROBEN, Alloc_Q1, Alloc_Q2,
               Alloc_V1, Alloc_V2, Alloc_Imm, CDB_ROBEN, CDB_Write_Data,
               FLUSH_Flag, FU_Ready,
        input  FULL_FLAG, Issue_Valid, Issue_opcode, Issue_ROBEN,
               Issue_V1, Issue_V2, Issue_Imm
    );

    modport slave (
        input  Alloc_Valid, Alloc_opcode, Alloc_ROBEN, Alloc_Q1, Alloc_Q2,
               Alloc_V1, Alloc_V2, Alloc_Imm, CDB_ROBEN, CDB_Write_Data,
               FLUSH_Flag, FU_Ready,
        output FULL_FLAG, Issue_Valid, Issue_opcode, Issue_ROBEN,
               Issue_V1, Issue_V2, Issue_Imm
    );

endinterface

// File: rtl/reservation_station_priority_select.sv
// -----------------------------------------------------------------------------
// rs_priority_select
// Lowest-index-set encoder.
//   req : request vector
//   gnt : one-hot grant of the lowest set bit of req (all zero when req == 0)
//   vld : any request present
// -----------------------------------------------------------------------------
module rs_priority_select #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] gnt,
    output logic         vld
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt = N'(1) << i;
            end
        end
        vld = |req;
    end

endmodule

// File: rtl/reservation_station.sv
// -----------------------------------------------------------------------------
// reservation_station
// Tomasulo reservation station in front of one functional unit. Dispatched
// instructions wait in a slot, tagged with their ROB entry, until both
// operands are known (captured from the CDB if needed); the lowest-index ready
// slot is presented to the FU and freed when the FU accepts it.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : reservation_station_if.slave (dispatch, CDB, flush, FU issue)
// -----------------------------------------------------------------------------
module reservation_station
    import reservation_station_pkg::*;
#(
    parameter int ENTRIES = 4,
    parameter int ROBEN_W = RS_ROBEN_W,
    parameter int DATA_W  = RS_DATA_W,
    parameter int OPC_W   = RS_OPC_W
) (
    input  logic                 clk,
    input  logic                 rst,
    reservation_station_if.slave bus
);

    typedef struct packed {
        logic               busy;
        logic [OPC_W-1:0]   opc;
        logic [ROBEN_W-1:0] roben;
        logic [ROBEN_W-1:0] q1;
        logic [ROBEN_W-1:0] q2;
        logic [DATA_W-1:0]  v1;
        logic [DATA_W-1:0]  v2;
        logic [DATA_W-1:0]  imm;
    } slot_t;

    slot_t slot_q [ENTRIES];
    slot_t slot_d [ENTRIES];
    slot_t new_slot;

    logic [ENTRIES-1:0] busy_vec;
    logic [ENTRIES-1:0] ready_vec;
    logic [ENTRIES-1:0] free_gnt;
    logic [ENTRIES-1:0] issue_gnt;
    logic               free_vld;
    logic               issue_vld;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            busy_vec[i]  = slot_q[i].busy;
            ready_vec[i] = slot_q[i].busy && (slot_q[i].q1 == NO_TAG)
                                          && (slot_q[i].q2 == NO_TAG);
        end
    end

    rs_priority_select #(.N(ENTRIES)) u_free_sel (
        .req (~busy_vec),
        .gnt (free_gnt),
        .vld (free_vld)
    );

    rs_priority_select #(.N(ENTRIES)) u_ready_sel (
        .req (ready_vec),
        .gnt (issue_gnt),
        .vld (issue_vld)
    );

    // Fullness depends on registered Busy only, so a slot freed by issue in
    // this same cycle cannot be reused until the next one.
    assign bus.FULL_FLAG   = ~free_vld;
    assign bus.Issue_Valid = issue_vld;

    // Issue mux: grant is one-hot or zero, so the fields fall to zero when
    // nothing is ready.
    always_comb begin
        bus.Issue_opcode = '0;
        bus.Issue_ROBEN  = '0;
        bus.Issue_V1     = '0;
        bus.Issue_V2     = '0;
        bus.Issue_Imm    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (issue_gnt[i]) begin
                bus.Issue_opcode = slot_q[i].opc;
                bus.Issue_ROBEN  = slot_q[i].roben;
                bus.Issue_V1     = slot_q[i].v1;
                bus.Issue_V2     = slot_q[i].v2;
                bus.Issue_Imm    = slot_q[i].imm;
            end
        end
    end

    // Incoming slot, with dispatch bypass: an operand whose producer is
    // broadcasting right now is stored as already valid.
    always_comb begin
        new_slot       = '0;
        new_slot.busy  = 1'b1;
        new_slot.opc   = bus.Alloc_opcode;
        new_slot.roben = bus.Alloc_ROBEN;
        new_slot.imm   = bus.Alloc_Imm;
        new_slot.q1    = bus.Alloc_Q1;
        new_slot.v1    = bus.Alloc_V1;
        new_slot.q2    = bus.Alloc_Q2;
        new_slot.v2    = bus.Alloc_V2;
        if (bus.Alloc_Q1 != NO_TAG && bus.Alloc_Q1 == bus.CDB_ROBEN) begin
            new_slot.q1 = NO_TAG;
            new_slot.v1 = bus.CDB_Write_Data;
        end
        if (bus.Alloc_Q2 != NO_TAG && bus.Alloc_Q2 == bus.CDB_ROBEN) begin
            new_slot.q2 = NO_TAG;
            new_slot.v2 = bus.CDB_Write_Data;
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            slot_d[i] = slot_q[i];
        end
        if (bus.FLUSH_Flag) begin
            // Flush wins over capture, issue-free and allocation.
            for (int i = 0; i < ENTRIES; i++) begin
                slot_d[i].busy = 1'b0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (slot_q[i].busy && bus.CDB_ROBEN != NO_TAG) begin
                    if (slot_q[i].q1 == bus.CDB_ROBEN) begin
                        slot_d[i].q1 = NO_TAG;
                        slot_d[i].v1 = bus.CDB_Write_Data;
                    end
                    if (slot_q[i].q2 == bus.CDB_ROBEN) begin
                        slot_d[i].q2 = NO_TAG;
                        slot_d[i].v2 = bus.CDB_Write_Data;
                    end
                end
                // Issued slot and allocated slot are never the same: one is
                // busy, the other free.
                if (issue_gnt[i] && bus.FU_Ready) begin
                    slot_d[i].busy = 1'b0;
                end
                if (free_gnt[i] && bus.Alloc_Valid) begin
                    slot_d[i] = new_slot;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: tb/tb_reservation_station.sv
// -----------------------------------------------------------------------------
// tb_reservation_station
// Directed scenarios followed by randomized traffic, all checked against a
// behavioural model of the reservation station's slot contents.
// -----------------------------------------------------------------------------
module tb_reservation_station;
    import reservation_station_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reservation_station_if bus ();

    reservation_station #(.ENTRIES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        busy;
        logic [11:0] opc;
        logic [4:0]  rob;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic [31:0] v1;
        logic [31:0] v2;
        logic [31:0] imm;
    } ent_t;

    ent_t m [N];

    task automatic model_reset();
        for (int i = 0; i < N; i++) m[i] = '0;
    endtask

    function automatic int ready_idx();
        for (int i = 0; i < N; i++)
            if (m[i].busy && m[i].q1 == 0 && m[i].q2 == 0) return i;
        return -1;
    endfunction

    function automatic int free_idx();
        for (int i = 0; i < N; i++)
            if (!m[i].busy) return i;
        return -1;
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        int   r;
        int   f;
        ent_t n;
        r = ready_idx();
        f = free_idx();
        if (bus.FLUSH_Flag) begin
            for (int i = 0; i < N; i++) m[i].busy = 1'b0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (m[i].busy && bus.CDB_ROBEN != 0) begin
                    if (m[i].q1 == bus.CDB_ROBEN) begin m[i].q1 = 0; m[i].v1 = bus.CDB_Write_Data; end
                    if (m[i].q2 == bus.CDB_ROBEN) begin m[i].q2 = 0; m[i].v2 = bus.CDB_Write_Data; end
                end
            end
            if (r >= 0 && bus.FU_Ready) m[r].busy = 1'b0;
            if (bus.Alloc_Valid && f >= 0) begin
                n.busy = 1'b1;
                n.opc  = bus.Alloc_opcode;
                n.rob  = bus.Alloc_ROBEN;
                n.imm  = bus.Alloc_Imm;
                n.q1   = bus.Alloc_Q1;
                n.v1   = bus.Alloc_V1;
                n.q2   = bus.Alloc_Q2;
                n.v2   = bus.Alloc_V2;
                if (n.q1 != 0 && n.q1 == bus.CDB_ROBEN) begin n.q1 = 0; n.v1 = bus.CDB_Write_Data; end
                if (n.q2 != 0 && n.q2 == bus.CDB_ROBEN) begin n.q2 = 0; n.v2 = bus.CDB_Write_Data; end
                m[f] = n;
            end
        end
    endtask

    task automatic compare_outputs(input string ph);
        int   r;
        ent_t e;
        r = ready_idx();
        e = (r >= 0) ? m[r] : '0;
        check_eq({ph, "_valid"}, bus.Issue_Valid, (r >= 0) ? 1 : 0);
        check_eq({ph, "_full"},  bus.FULL_FLAG,   (free_idx() < 0) ? 1 : 0);
        check_eq({ph, "_opc"},   bus.Issue_opcode, e.opc);
        check_eq({ph, "_rob"},   bus.Issue_ROBEN,  e.rob);
        check_eq({ph, "_v1"},    bus.Issue_V1,     e.v1);
        check_eq({ph, "_v2"},    bus.Issue_V2,     e.v2);
        check_eq({ph, "_imm"},   bus.Issue_Imm,    e.imm);
    endtask

    // One clock cycle: drive inputs, check outputs before the edge, step the
    // model, then return 1 time unit after the edge.
    task automatic cyc(input logic av, input logic [11:0] opc, input logic [4:0] rob,
                       input logic [4:0] q1, input logic [31:0] v1,
                       input logic [4:0] q2, input logic [31:0] v2,
                       input logic [4:0] ct, input logic [31:0] cd,
                       input logic fl, input logic fur);
        bus.Alloc_Valid    = av;
        bus.Alloc_opcode   = opc;
        bus.Alloc_ROBEN    = rob;
        bus.Alloc_Q1       = q1;
        bus.Alloc_V1       = v1;
        bus.Alloc_Q2       = q2;
        bus.Alloc_V2       = v2;
        bus.Alloc_Imm      = $urandom;
        bus.CDB_ROBEN      = ct;
        bus.CDB_Write_Data = cd;
        bus.FLUSH_Flag     = fl;
        bus.FU_Ready       = fur;
        #3;
        compare_outputs("cyc");
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic fur);
        cyc(1'b0, 12'h0, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, fur);
    endtask

    initial begin
        bus.Alloc_Valid = 0; bus.Alloc_opcode = 0; bus.Alloc_ROBEN = 0;
        bus.Alloc_Q1 = 0; bus.Alloc_Q2 = 0; bus.Alloc_V1 = 0; bus.Alloc_V2 = 0;
        bus.Alloc_Imm = 0; bus.CDB_ROBEN = 0; bus.CDB_Write_Data = 0;
        bus.FLUSH_Flag = 0; bus.FU_Ready = 0;
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        compare_outputs("rst");
        rst = 1'b1;

        // Ready-at-dispatch instruction issues next cycle
        cyc(1, OPC_ADD, 5'd3, 5'd0, 32'd5, 5'd0, 32'd7, 5'd0, 32'd0, 0, 0);
        check_eq("tp1_valid", bus.Issue_Valid, 1);
        check_eq("tp1_rob",   bus.Issue_ROBEN, 3);
        check_eq("tp1_opc",   bus.Issue_opcode, OPC_ADD);
        check_eq("tp1_v1",    bus.Issue_V1, 5);
        check_eq("tp1_v2",    bus.Issue_V2, 7);
        idle(1);
        check_eq("tp1_drained", bus.Issue_Valid, 0);

        // Two operands captured from successive broadcasts
        cyc(1, OPC_SUB, 5'd4, 5'd1, 32'd0, 5'd2, 32'd0, 5'd0, 32'd0, 0, 0);
        check_eq("tp2_wait", bus.Issue_Valid, 0);
        cyc(0, 12'h0, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd1, 32'd123, 0, 0);
        check_eq("tp2_half", bus.Issue_Valid, 0);
        cyc(0, 12'h0, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd2, 32'd456, 0, 0);
        check_eq("tp2_valid", bus.Issue_Valid, 1);
        check_eq("tp2_rob",   bus.Issue_ROBEN, 4);
        check_eq("tp2_v1",    bus.Issue_V1, 123);
        check_eq("tp2_v2",    bus.Issue_V2, 456);
        idle(1);

        // Dispatch bypass from the CDB
        cyc(1, OPC_AND, 5'd5, 5'd6, 32'd0, 5'd0, 32'd11, 5'd6, 32'd999, 0, 0);
        check_eq("tp3_valid", bus.Issue_Valid, 1);
        check_eq("tp3_rob",   bus.Issue_ROBEN, 5);
        check_eq("tp3_v1",    bus.Issue_V1, 999);
        check_eq("tp3_v2",    bus.Issue_V2, 11);
        idle(1);

        // Fill all slots, drop extra dispatch, free one
        for (int k = 0; k < N; k++)
            cyc(1, OPC_OR, 5'(8 + k), 5'(9 + k), 32'd0, 5'd0, 32'd2, 5'd0, 32'd0, 0, 0);
        check_eq("tp4_full", bus.FULL_FLAG, 1);
        cyc(1, OPC_ADD, 5'd13, 5'd0, 32'd1, 5'd0, 32'd1, 5'd0, 32'd0, 0, 0);
        check_eq("tp4_drop_full",  bus.FULL_FLAG, 1);
        check_eq("tp4_drop_valid", bus.Issue_Valid, 0);
        cyc(0, 12'h0, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd11, 32'd77, 0, 0);
        check_eq("tp4_res_valid", bus.Issue_Valid, 1);
        check_eq("tp4_res_rob",   bus.Issue_ROBEN, 10);
        check_eq("tp4_res_v1",    bus.Issue_V1, 77);
        // Acceptance edge with a dispatch attempt: still full at that edge
        cyc(1, OPC_ADD, 5'd14, 5'd0, 32'd3, 5'd0, 32'd4, 5'd0, 32'd0, 0, 1);
        check_eq("tp4_freed_full",  bus.FULL_FLAG, 0);
        check_eq("tp4_freed_valid", bus.Issue_Valid, 0);

        // Priority hold while the FU stalls
        cyc(0, 12'h0, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1, 0);
        check_eq("tp5_flush_full", bus.FULL_FLAG, 0);
        cyc(1, OPC_XOR, 5'd14, 5'd20, 32'd0, 5'd0, 32'd1, 5'd0, 32'd0, 0, 0);
        cyc(1, OPC_XOR, 5'd15, 5'd21, 32'd0, 5'd0, 32'd1, 5'd0, 32'd0, 0, 0);
        cyc(1, OPC_XOR, 5'd16, 5'd22, 32'd0, 5'd0, 32'd2, 5'd0, 32'd0, 0, 0);
        cyc(0, 12'h0, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd22, 32'd5, 0, 0);
        check_eq("tp5_s2_rob", bus.Issue_ROBEN, 16);
        cyc(0, 12'h0, 5'd0, 5'd0, 32'd0, 5'd0, 32'd0, 5'd20, 32'd6, 0, 0);
        check_eq("tp5_s0_rob", bus.Issue_ROBEN, 14);
        check_eq("tp5_s0_v1",  bus.Issue_V1, 6);
        for (int k = 0; k < 3; k++) begin
            idle(0);
            check_eq("tp5_hold_rob", bus.Issue_ROBEN, 14);
        end
        idle(1);
        check_eq("tp5_next_rob", bus.Issue_ROBEN, 16);
        idle(1);

        // Flush with allocation attempt, then asynchronous reset mid-cycle
        cyc(1, OPC_SLL, 5'd17, 5'd25, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0);
        cyc(1, OPC_SLL, 5'd18, 5'd26, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 0, 0);
        cyc(1, OPC_SLL, 5'd19, 5'd0, 32'd1, 5'd0, 32'd1, 5'd0, 32'd0, 1, 0);
        check_eq("tp6_flush_full",  bus.FULL_FLAG, 0);
        check_eq("tp6_flush_valid", bus.Issue_Valid, 0);
        cyc(1, OPC_SRL, 5'd20, 5'd0, 32'd8, 5'd0, 32'd9, 5'd0, 32'd0, 0, 0);
        check_eq("tp6_new_rob", bus.Issue_ROBEN, 20);
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_eq("tp6_rst_valid", bus.Issue_Valid, 0);
        check_eq("tp6_rst_rob",   bus.Issue_ROBEN, 0);
        @(posedge clk);
        #1;
        check_eq("tp6_rst_edge_valid", bus.Issue_Valid, 0);
        rst = 1'b1;

        // Randomized traffic
        for (int k = 0; k < 500; k++) begin
            logic [4:0] q1, q2, ct;
            q1 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            q2 = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            ct = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 7));
            cyc(1'($urandom_range(0, 1)), 12'($urandom), 5'($urandom_range(1, 31)),
                q1, $urandom, q2, $urandom, ct, $urandom,
                1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 2) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
